// File: rtl/commit_trace_buffer.sv
// Multi-lane retirement trace recorder: circular commit-record buffer with
// wrap/stop capture, PC-match trigger with post-trigger freeze, and an indexed read port.
module commit_trace_buffer #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 16,
   parameter int NRET  = 2,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic [NRET-1:0]      ret_valid_i,
   input  logic [NRET*XLEN-1:0] ret_pc_i,
   input  logic [NRET*XLEN-1:0] ret_instr_i,
   input  logic [NRET*5-1:0]    ret_rd_addr_i,
   input  logic [NRET*XLEN-1:0] ret_rd_data_i,
   input  logic                 mode_i,
   input  logic                 trig_en_i,
   input  logic [XLEN-1:0]      trig_pc_i,
   input  logic [CW-1:0]        post_trig_i,
   input  logic                 clear_i,
   input  logic [CW-2:0]        rd_idx_i,
   output logic [XLEN-1:0]      rd_pc_o,
   output logic [XLEN-1:0]      rd_instr_o,
   output logic [4:0]           rd_rd_addr_o,
   output logic [XLEN-1:0]      rd_rd_data_o,
   output logic                 rd_valid_o,
   output logic [CW-1:0]        count_o,
   output logic [1:0]           state_o,
   output logic                 overflow_o,
   output logic                 trig_hit_o
);

   localparam int            AW   = CW - 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {
      ST_CAPTURE = 2'd0,
      ST_POST    = 2'd1,
      ST_FROZEN  = 2'd2
   } state_t;

   logic [XLEN-1:0] pcMem_q    [DEPTH];
   logic [XLEN-1:0] instrMem_q [DEPTH];
   logic [4:0]      rdAddrMem_q[DEPTH];
   logic [XLEN-1:0] rdDataMem_q[DEPTH];

   state_t          state_q, state_d;
   logic [AW-1:0]   wrPtr_q, wrPtr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [CW-1:0]   postCnt_q, postCnt_d;
   logic            overflow_q, overflow_d;
   logic            trigHit_q, trigHit_d;

   logic [NRET-1:0] wrEn;
   logic [AW-1:0]   wrAddr [NRET];
   logic            laneStore;

   logic [AW-1:0]   rdAddr;
   logic            rdHit;
   logic [XLEN-1:0] rdPc_q, rdInstr_q, rdData_q;
   logic [4:0]      rdRdAddr_q;
   logic            rdValid_q;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q    <= ST_CAPTURE;
         wrPtr_q    <= '0;
         count_q    <= '0;
         postCnt_q  <= '0;
         overflow_q <= 1'b0;
         trigHit_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wrPtr_q    <= wrPtr_d;
         count_q    <= count_d;
         postCnt_q  <= postCnt_d;
         overflow_q <= overflow_d;
         trigHit_q  <= trigHit_d;
      end
   end

   // Lanes are walked oldest-first so a state change caused by lane 0 (trigger
   // hit or freeze) governs what happens to lane 1 in the same cycle.
   always_comb begin
      state_d    = state_q;
      wrPtr_d    = wrPtr_q;
      count_d    = count_q;
      postCnt_d  = postCnt_q;
      overflow_d = overflow_q;
      trigHit_d  = trigHit_q;
      wrEn       = '0;
      laneStore  = 1'b0;
      for (int l = 0; l < NRET; l++) begin
         wrAddr[l] = '0;
      end

      if (clear_i) begin
         state_d    = ST_CAPTURE;
         wrPtr_d    = '0;
         count_d    = '0;
         postCnt_d  = '0;
         overflow_d = 1'b0;
         trigHit_d  = 1'b0;
      end else begin
         for (int l = 0; l < NRET; l++) begin
            laneStore = 1'b0;
            if (ret_valid_i[l] && (state_d != ST_FROZEN)) begin
               if (mode_i && (count_d == FULL)) begin
                  overflow_d = 1'b1;
               end else begin
                  wrEn[l]   = 1'b1;
                  wrAddr[l] = wrPtr_d;
                  wrPtr_d   = wrPtr_d + AW'(1);
                  laneStore = 1'b1;
                  if (count_d == FULL) begin
                     overflow_d = 1'b1;
                  end else begin
                     count_d = count_d + CW'(1);
                  end
               end

               if (state_d == ST_POST) begin
                  if (laneStore) begin
                     postCnt_d = postCnt_d - CW'(1);
                     if (postCnt_d == '0) begin
                        state_d = ST_FROZEN;
                     end
                  end
               end else if (trig_en_i && (ret_pc_i[l*XLEN +: XLEN] == trig_pc_i)) begin
                  trigHit_d = 1'b1;
                  postCnt_d = post_trig_i;
                  state_d   = (post_trig_i == '0) ? ST_FROZEN : ST_POST;
               end
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      for (int l = 0; l < NRET; l++) begin
         if (wrEn[l]) begin
            pcMem_q[wrAddr[l]]     <= ret_pc_i[l*XLEN +: XLEN];
            instrMem_q[wrAddr[l]]  <= ret_instr_i[l*XLEN +: XLEN];
            rdAddrMem_q[wrAddr[l]] <= ret_rd_addr_i[l*5 +: 5];
            rdDataMem_q[wrAddr[l]] <= ret_rd_data_i[l*XLEN +: XLEN];
         end
      end
   end

   // Index 0 maps to the oldest stored entry; data is zeroed for empty slots so
   // uninitialised storage never leaks out.
   assign rdAddr = wrPtr_q - count_q[AW-1:0] + rd_idx_i;
   assign rdHit  = ({1'b0, rd_idx_i} < count_q);

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         rdPc_q     <= '0;
         rdInstr_q  <= '0;
         rdRdAddr_q <= '0;
         rdData_q   <= '0;
         rdValid_q  <= 1'b0;
      end else if (rdHit) begin
         rdPc_q     <= pcMem_q[rdAddr];
         rdInstr_q  <= instrMem_q[rdAddr];
         rdRdAddr_q <= rdAddrMem_q[rdAddr];
         rdData_q   <= rdDataMem_q[rdAddr];
         rdValid_q  <= 1'b1;
      end else begin
         rdPc_q     <= '0;
         rdInstr_q  <= '0;
         rdRdAddr_q <= '0;
         rdData_q   <= '0;
         rdValid_q  <= 1'b0;
      end
   end

   assign rd_pc_o      = rdPc_q;
   assign rd_instr_o   = rdInstr_q;
   assign rd_rd_addr_o = rdRdAddr_q;
   assign rd_rd_data_o = rdData_q;
   assign rd_valid_o   = rdValid_q;
   assign count_o      = count_q;
   assign state_o      = state_q;
   assign overflow_o   = overflow_q;
   assign trig_hit_o   = trigHit_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed self-checking bench for commit_trace_buffer: fill/wrap, stop mode,
// trigger and post-trigger freeze, lane packing, clear and async reset.
module tb_commit_trace_buffer;

   localparam int XLEN  = 32;
   localparam int DEPTH = 16;
   localparam int NRET  = 2;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic                 clk_i;
   logic                 rstn_i;
   logic [NRET-1:0]      ret_valid_i;
   logic [NRET*XLEN-1:0] ret_pc_i;
   logic [NRET*XLEN-1:0] ret_instr_i;
   logic [NRET*5-1:0]    ret_rd_addr_i;
   logic [NRET*XLEN-1:0] ret_rd_data_i;
   logic                 mode_i;
   logic                 trig_en_i;
   logic [XLEN-1:0]      trig_pc_i;
   logic [CW-1:0]        post_trig_i;
   logic                 clear_i;
   logic [CW-2:0]        rd_idx_i;
   logic [XLEN-1:0]      rd_pc_o;
   logic [XLEN-1:0]      rd_instr_o;
   logic [4:0]           rd_rd_addr_o;
   logic [XLEN-1:0]      rd_rd_data_o;
   logic                 rd_valid_o;
   logic [CW-1:0]        count_o;
   logic [1:0]           state_o;
   logic                 overflow_o;
   logic                 trig_hit_o;

   int passCount = 0;
   int failCount = 0;
   int totalCount = 0;

   commit_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .NRET(NRET), .CW(CW)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i),
      .ret_valid_i(ret_valid_i), .ret_pc_i(ret_pc_i), .ret_instr_i(ret_instr_i),
      .ret_rd_addr_i(ret_rd_addr_i), .ret_rd_data_i(ret_rd_data_i),
      .mode_i(mode_i), .trig_en_i(trig_en_i), .trig_pc_i(trig_pc_i),
      .post_trig_i(post_trig_i), .clear_i(clear_i), .rd_idx_i(rd_idx_i),
      .rd_pc_o(rd_pc_o), .rd_instr_o(rd_instr_o), .rd_rd_addr_o(rd_rd_addr_o),
      .rd_rd_data_o(rd_rd_data_o), .rd_valid_o(rd_valid_o), .count_o(count_o),
      .state_o(state_o), .overflow_o(overflow_o), .trig_hit_o(trig_hit_o)
   );

   // 10 ns clock
   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Hard stop in case the sequence ever stalls
   initial begin
      #200000;
      $display("[TB] FAIL timeout observed=running expected=finished");
      $fatal(1, "[TB] timeout");
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      totalCount++;
      assert (observed === expected) begin
         passCount++;
      end else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drive one retire cycle; lane 0 carries rd=1 and data=pc+0x1000, instr={A5A5,pc[15:0]}
   task automatic applyStimulus(input logic [1:0] valid, input logic [31:0] pc0, input logic [31:0] pc1,
                                input logic [4:0] rd1, input logic [31:0] data1);
      ret_valid_i   = valid;
      ret_pc_i      = {pc1, pc0};
      ret_instr_i   = {16'hA5A5, pc1[15:0], 16'hA5A5, pc0[15:0]};
      ret_rd_addr_i = {rd1, 5'd1};
      ret_rd_data_i = {data1, pc0 + 32'h1000};
      tick();
      ret_valid_i   = '0;
   endtask

   task automatic commit1(input logic [31:0] pc);
      applyStimulus(2'b01, pc, 32'h0, 5'd0, 32'h0);
   endtask

   task automatic commit2(input logic [31:0] pc0, input logic [31:0] pc1);
      applyStimulus(2'b11, pc0, pc1, 5'd2, pc1 + 32'h1000);
   endtask

   task automatic readEntry(input logic [CW-2:0] idx);
      ret_valid_i = '0;
      rd_idx_i    = idx;
      tick();
   endtask

   task automatic doClear();
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
   endtask

   initial begin
      rstn_i = 1'b0; ret_valid_i = '0; ret_pc_i = '0; ret_instr_i = '0;
      ret_rd_addr_i = '0; ret_rd_data_i = '0; mode_i = 1'b0; trig_en_i = 1'b0;
      trig_pc_i = '0; post_trig_i = '0; clear_i = 1'b0; rd_idx_i = '0;

      #12;
      checkOutput("reset_count", 64'(count_o), 64'd0);
      checkOutput("reset_state", 64'(state_o), 64'd0);
      checkOutput("reset_valid", 64'(rd_valid_o), 64'd0);
      checkOutput("reset_pc", 64'(rd_pc_o), 64'd0);
      checkOutput("reset_ovf", 64'(overflow_o), 64'd0);
      checkOutput("reset_hit", 64'(trig_hit_o), 64'd0);
      @(posedge clk_i); #1;
      rstn_i = 1'b1;
      tick();

      // Single-lane wrap fill: 20 commits into 16 slots
      $display("[TB] single-lane wrap fill");
      for (int i = 0; i < 20; i++) commit1(32'(i * 4));
      checkOutput("wrap_count", 64'(count_o), 64'd16);
      checkOutput("wrap_ovf", 64'(overflow_o), 64'd1);
      checkOutput("wrap_state", 64'(state_o), 64'd0);
      readEntry(4'd0);
      checkOutput("wrap_idx0_pc", 64'(rd_pc_o), 64'h10);
      checkOutput("wrap_idx0_instr", 64'(rd_instr_o), 64'hA5A50010);
      checkOutput("wrap_idx0_data", 64'(rd_rd_data_o), 64'h1010);
      checkOutput("wrap_idx0_valid", 64'(rd_valid_o), 64'd1);
      readEntry(4'd15);
      checkOutput("wrap_idx15_pc", 64'(rd_pc_o), 64'h4C);

      // Clear, then stop mode with a dual-lane commit into the last free slot
      $display("[TB] stop mode");
      doClear();
      checkOutput("clear_count", 64'(count_o), 64'd0);
      checkOutput("clear_ovf", 64'(overflow_o), 64'd0);
      mode_i = 1'b1;
      for (int i = 0; i < 15; i++) commit1(32'(i * 4));
      checkOutput("stop_count15", 64'(count_o), 64'd15);
      checkOutput("stop_ovf15", 64'(overflow_o), 64'd0);
      commit2(32'h100, 32'h104);
      checkOutput("stop_count16", 64'(count_o), 64'd16);
      checkOutput("stop_ovf16", 64'(overflow_o), 64'd1);
      readEntry(4'd15);
      checkOutput("stop_idx15_pc", 64'(rd_pc_o), 64'h100);
      commit1(32'h200);
      readEntry(4'd15);
      checkOutput("stop_drop_pc", 64'(rd_pc_o), 64'h100);
      checkOutput("stop_drop_count", 64'(count_o), 64'd16);

      // Trigger at 0x40 with 3 post entries
      $display("[TB] trigger with post count");
      mode_i = 1'b0;
      doClear();
      trig_en_i = 1'b1; trig_pc_i = 32'h40; post_trig_i = 5'd3;
      for (int i = 0; i < 28; i++) begin
         commit1(32'(i * 4));
         if (i == 16) checkOutput("trig_state_post", 64'(state_o), 64'd1);
      end
      checkOutput("trig_state_frozen", 64'(state_o), 64'd2);
      checkOutput("trig_hit", 64'(trig_hit_o), 64'd1);
      checkOutput("trig_count", 64'(count_o), 64'd16);
      readEntry(4'd15);
      checkOutput("trig_last_pc", 64'(rd_pc_o), 64'h4C);
      readEntry(4'd0);
      checkOutput("trig_first_pc", 64'(rd_pc_o), 64'h10);

      // Same-cycle trigger, post 1: both lanes stored, frozen
      $display("[TB] same-cycle trigger");
      doClear();
      checkOutput("clear_hit", 64'(trig_hit_o), 64'd0);
      trig_pc_i = 32'h300; post_trig_i = 5'd1;
      commit1(32'h2F0);
      commit2(32'h300, 32'h304);
      checkOutput("same1_count", 64'(count_o), 64'd3);
      checkOutput("same1_state", 64'(state_o), 64'd2);
      commit1(32'h308);
      checkOutput("same1_frozen_count", 64'(count_o), 64'd3);
      readEntry(4'd2);
      checkOutput("same1_idx2_pc", 64'(rd_pc_o), 64'h304);

      // Same-cycle trigger, post 0: lane 1 not stored
      doClear();
      post_trig_i = 5'd0;
      commit2(32'h300, 32'h304);
      checkOutput("same0_count", 64'(count_o), 64'd1);
      checkOutput("same0_state", 64'(state_o), 64'd2);
      readEntry(4'd0);
      checkOutput("same0_idx0_pc", 64'(rd_pc_o), 64'h300);
      readEntry(4'd1);
      checkOutput("same0_idx1_valid", 64'(rd_valid_o), 64'd0);
      checkOutput("same0_idx1_pc", 64'(rd_pc_o), 64'd0);

      // Lane 1 valid alone is packed at wr_ptr
      $display("[TB] non-contiguous lanes");
      doClear();
      trig_en_i = 1'b0;
      commit1(32'h1F0);
      applyStimulus(2'b10, 32'h0, 32'h200, 5'd7, 32'hDEADBEEF);
      checkOutput("lane1_count", 64'(count_o), 64'd2);
      readEntry(4'd1);
      checkOutput("lane1_pc", 64'(rd_pc_o), 64'h200);
      checkOutput("lane1_rd", 64'(rd_rd_addr_o), 64'd7);
      checkOutput("lane1_data", 64'(rd_rd_data_o), 64'hDEADBEEF);
      checkOutput("lane1_valid", 64'(rd_valid_o), 64'd1);

      // Clear in the middle of POST
      $display("[TB] clear and reset mid-post");
      doClear();
      trig_en_i = 1'b1; trig_pc_i = 32'h500; post_trig_i = 5'd5;
      commit2(32'h500, 32'h504);
      checkOutput("midpost_state", 64'(state_o), 64'd1);
      checkOutput("midpost_count", 64'(count_o), 64'd2);
      doClear();
      checkOutput("midclr_count", 64'(count_o), 64'd0);
      checkOutput("midclr_state", 64'(state_o), 64'd0);
      checkOutput("midclr_hit", 64'(trig_hit_o), 64'd0);
      readEntry(4'd0);
      checkOutput("midclr_valid", 64'(rd_valid_o), 64'd0);

      // Asynchronous reset in the middle of POST, between edges
      commit1(32'h500);
      checkOutput("midrst_pre_state", 64'(state_o), 64'd1);
      readEntry(4'd0);
      checkOutput("midrst_pre_valid", 64'(rd_valid_o), 64'd1);
      checkOutput("midrst_pre_pc", 64'(rd_pc_o), 64'h500);
      #2;
      rstn_i = 1'b0;
      #1;
      checkOutput("midrst_count", 64'(count_o), 64'd0);
      checkOutput("midrst_state", 64'(state_o), 64'd0);
      checkOutput("midrst_hit", 64'(trig_hit_o), 64'd0);
      checkOutput("midrst_valid", 64'(rd_valid_o), 64'd0);
      checkOutput("midrst_pc", 64'(rd_pc_o), 64'd0);
      #2;
      rstn_i = 1'b1;
      tick();
      checkOutput("postrst_count", 64'(count_o), 64'd0);

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
